// File: rtl/load_store_unit.sv
// Load/store unit: turns a core byte/half/word access into one word-addressed,
// byte-enabled memory transaction. The core is stalled while the transaction is
// in flight, and load data is extended on return.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_require,
  input  logic        core_write_enable,
  input  logic [2:0]  core_size,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  output logic        fault,
  output logic        mem_require,
  output logic        mem_write_enable,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic TIMEOUT_ON = (TIMEOUT != 0);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt, cnt_d;
  logic [31:0]       rdata_q, capture_data;
  logic              capture, accept;
  logic              we_q;
  logic [2:0]        size_q;
  logic [1:0]        lo_q;
  logic [3:0]        be_q;
  logic [29:0]       addr_q;
  logic [31:0]       wd_q;

  logic              size_ok, aligned, req_legal;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic [31:0]       shifted, load_ext;

  // Decode the incoming request: legality, lane enables, replicated store data.
  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b1;
    req_be  = 4'b0000;
    req_wd  = core_write_data;
    case (core_size)
      SZ_B, SZ_BU: begin
        size_ok = 1'b1;
        req_be  = 4'b0001 << core_address[1:0];
        req_wd  = {4{core_write_data[7:0]}};
      end
      SZ_H, SZ_HU: begin
        size_ok = 1'b1;
        aligned = ~core_address[0];
        req_be  = 4'b0011 << core_address[1:0];
        req_wd  = {2{core_write_data[15:0]}};
      end
      SZ_W: begin
        size_ok = 1'b1;
        aligned = (core_address[1:0] == 2'b00);
        req_be  = 4'b1111;
      end
      default: ;
    endcase
    req_legal = size_ok & aligned;
  end

  // Extract and extend the addressed byte/halfword from the captured word.
  always_comb begin
    shifted = rdata_q >> {lo_q, 3'b000};
    case (size_q)
      SZ_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      SZ_BU:   load_ext = {24'd0, shifted[7:0]};
      SZ_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      SZ_HU:   load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state and output logic; reset forces stall and fault low.
  always_comb begin
    state_d          = state_q;
    cnt_d            = wait_cnt;
    accept           = 1'b0;
    capture          = 1'b0;
    capture_data     = '0;
    core_stall       = 1'b0;
    fault            = 1'b0;
    core_read_data   = '0;
    mem_require      = 1'b0;
    mem_write_enable = 1'b0;
    mem_byte_enable  = 4'b0000;
    mem_address      = '0;
    mem_write_data   = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (core_require) begin
          if (req_legal) begin
            accept     = 1'b1;
            core_stall = 1'b1;
            state_d    = S_WAIT;
          end else begin
            fault = 1'b1;
          end
        end
      end
      S_WAIT: begin
        core_stall       = 1'b1;
        mem_require      = 1'b1;
        mem_write_enable = we_q;
        mem_byte_enable  = be_q;
        mem_address      = {addr_q, 2'b00};
        mem_write_data   = wd_q;
        if (mem_ready) begin
          capture      = 1'b1;
          capture_data = we_q ? 32'd0 : mem_read_data;
          cnt_d        = '0;
          state_d      = S_DONE;
        end else if (TIMEOUT_ON && (wait_cnt == CNT_LAST)) begin
          fault        = 1'b1;
          capture      = 1'b1;
          capture_data = '0;
          cnt_d        = '0;
          state_d      = S_DONE;
        end else begin
          cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        core_read_data = we_q ? 32'd0 : load_ext;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      core_stall = 1'b0;
      fault      = 1'b0;
    end
  end

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= cnt_d;
    end
  end

  // Latch the accepted request so the bus stays stable during WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      size_q <= 3'd0;
      lo_q   <= 2'd0;
      be_q   <= 4'd0;
      addr_q <= '0;
      wd_q   <= '0;
    end else if (accept) begin
      we_q   <= core_write_enable;
      size_q <= core_size;
      lo_q   <= core_address[1:0];
      be_q   <= req_be;
      addr_q <= core_address[31:2];
      wd_q   <= req_wd;
    end
  end

  // Capture returned read data (zero on store or timeout).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= capture_data;
    end
  end

endmodule
